// File: rtl/pulse_stretch.sv
// Pulse stretcher: each input event becomes an ON_CYCLES-long led_out burst followed by an
// OFF_CYCLES low gap. Define PULSE_STRETCH_QUEUE_EN to queue events that arrive mid-burst.
module pulse_stretch #(
  parameter int unsigned ON_CYCLES  = 'hF4240,
  parameter int unsigned OFF_CYCLES = 'hF4240,
  parameter int unsigned QW         = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pulse_in,
  output logic          led_out,
  output logic          busy,
  output logic [QW-1:0] pending,
  output logic          overflow
);

  localparam logic [19:0] OnLast  = 20'(ON_CYCLES - 1);
  localparam logic [19:0] OffLast = 20'(OFF_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StOn, StGap} state_e;

  state_e        state_q, state_d;
  logic [19:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [QW-1:0] pending_q;
  logic          gap_last;
  logic          evt_busy;

  assign gap_last = (state_q == StGap) && (cnt_q == OffLast);
  // The final gap cycle is excluded: a pulse there restarts a burst instead of queueing.
  assign evt_busy = pulse_in && ((state_q == StOn) || ((state_q == StGap) && !gap_last));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pulse_in) state_d = StOn;
      StOn:    if (cnt_q == OnLast) state_d = StGap;
      StGap:   if (gap_last) state_d = (pulse_in || (pending_q != '0)) ? StOn : StIdle;
      default: state_d = StIdle;
    endcase
    cnt_d = ((state_d != state_q) || (state_q == StIdle)) ? 20'd0 : cnt_q + 20'd1;
  end

`ifdef PULSE_STRETCH_QUEUE_EN
  localparam logic [QW-1:0] PendMax = {QW{1'b1}};

  logic [QW-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    ovf_d     = 1'b0;
    if (evt_busy) begin
      if (pending_q == PendMax) begin
        ovf_d = 1'b1;
      end else begin
        pending_d = pending_q + QW'(1);
      end
    end else if (gap_last && !pulse_in && (pending_q != '0)) begin
      // A fresh pulse on the final gap cycle takes the next burst itself, leaving the queue.
      pending_d = pending_q - QW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end
`else
  assign pending_q = '0;
  assign ovf_d     = evt_busy;
`endif

  always_comb begin
    led_out  = (state_q == StOn);
    busy     = (state_q != StIdle);
    pending  = pending_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch: directed scenarios plus random pulses/resets, checked every cycle
// against a time-based reference model (burst start time + queue count).
module tb_pulse_stretch;

  localparam int OnC  = 4;
  localparam int OffC = 2;
  localparam int Qw   = 2;
  localparam int PMax = (1 << Qw) - 1;

`ifdef PULSE_STRETCH_QUEUE_EN
  localparam bit QueueEn = 1'b1;
`else
  localparam bit QueueEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          pulse_in;
  logic          led_out;
  logic          busy;
  logic [Qw-1:0] pending;
  logic          overflow;

  pulse_stretch #(
    .ON_CYCLES (OnC),
    .OFF_CYCLES(OffC),
    .QW        (Qw)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .pulse_in(pulse_in),
    .led_out (led_out),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;  // index of the current cycle

  // Reference model: a burst is "active" from its start cycle until the gap ends.
  bit m_active = 1'b0;
  int m_start  = 0;
  int m_pend   = 0;
  bit m_ovf    = 1'b0;

  int  bursts   = 0;
  logic prev_led = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  // Apply the rules for the cycle that just ended (inputs p, r); yields next-cycle state.
  task automatic model_edge(input bit p, input bit r);
    int e;
    m_ovf = 1'b0;
    if (r) begin
      m_active = 1'b0;
      m_pend   = 0;
    end else if (!m_active) begin
      if (p) begin
        m_active = 1'b1;
        m_start  = t + 1;
      end
    end else begin
      e = t - m_start;
      if (e < OnC + OffC - 1) begin
        if (p) begin
          if (QueueEn && m_pend < PMax) m_pend++;
          else m_ovf = 1'b1;
        end
      end else if (p) begin
        m_start = t + 1;
      end else if (m_pend > 0) begin
        m_pend--;
        m_start = t + 1;
      end else begin
        m_active = 1'b0;
      end
    end
    t++;
  endtask

  task automatic step(input bit p, input bit r);
    bit exp_led;
    pulse_in = p;
    rst      = r;
    @(posedge clk);
    model_edge(p, r);
    #1;
    exp_led = m_active && ((t - m_start) < OnC);
    check("led_out", 32'(led_out), 32'(exp_led));
    check("busy", 32'(busy), 32'(m_active));
    check("pending", 32'(pending), 32'(m_pend));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (led_out === 1'b1 && prev_led !== 1'b1) bursts++;
    prev_led = led_out;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    pulse_in = 1'b0;
    rst      = 1'b1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Single pulse
    bursts = 0;
    idle(8);
    step(1'b1, 1'b0);
    idle(20);
    check("single_bursts", 32'(bursts), 32'd1);

    // Saturation: one starting pulse plus four while ON
    bursts = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    idle(40);
    check("sat_bursts", 32'(bursts), QueueEn ? 32'd4 : 32'd1);

    // Back-to-back: pulse lands on the final gap cycle
    bursts = 0;
    step(1'b1, 1'b0);
    idle(OnC + OffC - 1);
    step(1'b1, 1'b0);
    idle(20);
    check("b2b_bursts", 32'(bursts), 32'd2);

    // Reset mid-burst with a pulse alongside it
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    bursts = 0;
    idle(20);
    check("rst_bursts", 32'(bursts), 32'd0);

    // Random traffic with varying density and occasional resets
    for (int i = 0; i < 3000; i++) begin
      int dens;
      dens = (i / 500) % 2 == 0 ? 35 : 80;
      step(1'($urandom_range(0, 99) < dens), 1'($urandom_range(0, 199) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
